attribute_access_arbiter: RTL and testbench

ATTRIBUTE_ACCESS_ARBITER -- requirements
Module: attribute_access_arbiter

---
 rtl/attribute_access_arbiter.sv | 166 ++++++++++++++++
 tb/tb_attribute_access_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attribute_access_arbiter.sv
// Attribute memory arbiter: buffers CPU writes in a small FIFO and slots
// CPU reads/writes around renderer reads, forcing access after a wait limit.
module attribute_access_arbiter #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int FIFO_DEPTH    = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cpu_wr_valid,
    output logic                     cpu_wr_ready,
    input  logic [ADDRESS_WIDTH-1:0] cpu_wr_addr,
    input  logic [7:0]               cpu_wr_data,
    input  logic                     cpu_rd_valid,
    output logic                     cpu_rd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cpu_rd_addr,
    output logic                     cpu_rd_data_valid,
    output logic [7:0]               cpu_rd_data,
    input  logic                     render_rd_enable,
    input  logic [ADDRESS_WIDTH-1:0] render_rd_addr,
    output logic                     render_stall,
    output logic                     mem_read_enable,
    output logic [ADDRESS_WIDTH-1:0] mem_read_addr,
    input  logic [7:0]               mem_read_data,
    output logic                     mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0] mem_write_addr,
    output logic [7:0]               mem_write_data
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C  = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_PENDING,
        RD_ISSUE,
        RD_RETURN
    } rd_state_e;

    logic [ADDRESS_WIDTH-1:0] addr_q [FIFO_DEPTH];
    logic [7:0]               data_q [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr_q;
    logic [PW-1:0]            rd_ptr_q;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;
    logic [SW-1:0]            wcnt_q;
    logic [SW-1:0]            wcnt_d;

    rd_state_e                state_q;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q;
    logic [SW-1:0]            rcnt_q;
    logic                     rd_ready_q;
    logic                     issue_q;
    logic                     ret_q;

    logic fifo_empty;
    logic push;
    logic drain;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign fifo_empty   = (count_q == '0);
    assign cpu_wr_ready = (count_q < DEPTH_C);
    assign push         = cpu_wr_valid && cpu_wr_ready;
    // Drain decision uses the registered count, so a fresh word waits a cycle.
    assign drain        = !fifo_empty &&
                          (!render_rd_enable || (wcnt_q == LIMIT_C));

    always_comb begin
        count_d = count_q;
        if (push && !drain) begin
            count_d = count_q + CW'(1);
        end else if (drain && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    assign wcnt_d = (fifo_empty || drain) ? '0 : wcnt_q + SW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wcnt_q   <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= cpu_wr_addr;
                data_q[wr_ptr_q] <= cpu_wr_data;
                wr_ptr_q         <= bump(wr_ptr_q);
            end
            if (drain) begin
                rd_ptr_q <= bump(rd_ptr_q);
            end
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // A read only leaves PENDING once every earlier write has reached memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RD_IDLE;
            rd_addr_q  <= '0;
            rcnt_q     <= '0;
            rd_ready_q <= 1'b1;
            issue_q    <= 1'b0;
            ret_q      <= 1'b0;
        end else begin
            unique case (state_q)
                RD_IDLE: begin
                    if (cpu_rd_valid) begin
                        rd_addr_q  <= cpu_rd_addr;
                        rd_ready_q <= 1'b0;
                        state_q    <= RD_PENDING;
                    end
                end
                RD_PENDING: begin
                    if (fifo_empty) begin
                        if (!render_rd_enable || (rcnt_q == LIMIT_C)) begin
                            rcnt_q  <= '0;
                            issue_q <= 1'b1;
                            state_q <= RD_ISSUE;
                        end else begin
                            rcnt_q <= rcnt_q + SW'(1);
                        end
                    end
                end
                RD_ISSUE: begin
                    issue_q <= 1'b0;
                    ret_q   <= 1'b1;
                    state_q <= RD_RETURN;
                end
                RD_RETURN: begin
                    ret_q      <= 1'b0;
                    rd_ready_q <= 1'b1;
                    state_q    <= RD_IDLE;
                end
            endcase
        end
    end

    assign cpu_rd_ready      = rd_ready_q;
    assign cpu_rd_data_valid = ret_q;
    assign cpu_rd_data       = ret_q ? mem_read_data : '0;

    assign mem_read_enable   = issue_q ? 1'b1 : render_rd_enable;
    assign mem_read_addr     = issue_q ? rd_addr_q : render_rd_addr;
    assign render_stall      = issue_q && render_rd_enable;

    assign mem_write_enable  = drain;
    assign mem_write_addr    = drain ? addr_q[rd_ptr_q] : '0;
    assign mem_write_data    = drain ? data_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_attribute_access_arbiter.sv
// Bench for attribute_access_arbiter: vector table plus corner sequences,
// write/read scoreboards checked against a behavioural memory.
module tb_attribute_access_arbiter;

    localparam int AW    = 12;
    localparam int LIMIT = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            c;
    } wexp_t;

    typedef struct {
        logic [7:0] d;
        int         c;
    } rexp_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [7:0]    exp;
        int            lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_wr_valid;
    logic          cpu_wr_ready;
    logic [AW-1:0] cpu_wr_addr;
    logic [7:0]    cpu_wr_data;
    logic          cpu_rd_valid;
    logic          cpu_rd_ready;
    logic [AW-1:0] cpu_rd_addr;
    logic          cpu_rd_data_valid;
    logic [7:0]    cpu_rd_data;
    logic          render_rd_enable;
    logic [AW-1:0] render_rd_addr;
    logic          render_stall;
    logic          mem_read_enable;
    logic [AW-1:0] mem_read_addr;
    logic [7:0]    mem_read_data = 8'h00;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_addr;
    logic [7:0]    mem_write_data;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int n_wr      = 0;
    int n_ret     = 0;
    int stall_n   = 0;
    int stall_cyc = 0;
    logic [AW-1:0] stall_addr = '0;

    wexp_t wq[$];
    rexp_t rq[$];
    wexp_t mw;
    rexp_t mr;
    vec_t  vt [5];

    bit [7:0] mem  [4096];
    bit       mark [4096];

    attribute_access_arbiter #(
        .ADDRESS_WIDTH(AW),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cpu_wr_valid     (cpu_wr_valid),
        .cpu_wr_ready     (cpu_wr_ready),
        .cpu_wr_addr      (cpu_wr_addr),
        .cpu_wr_data      (cpu_wr_data),
        .cpu_rd_valid     (cpu_rd_valid),
        .cpu_rd_ready     (cpu_rd_ready),
        .cpu_rd_addr      (cpu_rd_addr),
        .cpu_rd_data_valid(cpu_rd_data_valid),
        .cpu_rd_data      (cpu_rd_data),
        .render_rd_enable (render_rd_enable),
        .render_rd_addr   (render_rd_addr),
        .render_stall     (render_stall),
        .mem_read_enable  (mem_read_enable),
        .mem_read_addr    (mem_read_addr),
        .mem_read_data    (mem_read_data),
        .mem_write_enable (mem_write_enable),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unwritten locations read back as addr[7:0] ^ 0x3C (so 0x200 holds 0x3C).
    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_write_addr]  <= mem_write_data;
            mark[mem_write_addr] <= 1'b1;
        end
        if (mem_read_enable) begin
            mem_read_data <= mark[mem_read_addr] ? mem[mem_read_addr]
                                                 : (mem_read_addr[7:0] ^ 8'h3C);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_write_enable) begin
                n_wr++;
                if (wq.size() == 0) begin
                    miss("unexpected_write");
                end else begin
                    mw = wq.pop_front();
                    chk("wr_addr", 32'(mem_write_addr), 32'(mw.a));
                    chk("wr_data", 32'(mem_write_data), 32'(mw.d));
                    if (mw.c >= 0) chk("wr_cycle", cyc, mw.c);
                end
            end
            if (cpu_rd_data_valid) begin
                n_ret++;
                if (rq.size() == 0) begin
                    miss("unexpected_return");
                end else begin
                    mr = rq.pop_front();
                    chk("rd_data", 32'(cpu_rd_data), 32'(mr.d));
                    if (mr.c >= 0) chk("rd_cycle", cyc, mr.c);
                end
            end
            if (render_stall) begin
                stall_n++;
                stall_cyc  = cyc;
                stall_addr = mem_read_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [7:0] d,
                        input int lat);
        int n = 0;
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = a;
        cpu_wr_data  = d;
        while (!cpu_wr_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cpu_wr_ready) begin
            miss("push_timeout");
            cpu_wr_valid = 1'b0;
            return;
        end
        wq.push_back('{a, d, (lat < 0) ? -1 : cyc + lat});
        tick();
        cpu_wr_valid = 1'b0;
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [7:0] exp,
                        input int lat, output int k);
        int n = 0;
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = a;
        while (!cpu_rd_ready && n < 200) begin
            tick();
            n++;
        end
        k = cyc;
        if (!cpu_rd_ready) begin
            miss("read_timeout");
            cpu_rd_valid = 1'b0;
            return;
        end
        rq.push_back('{exp, (lat < 0) ? -1 : cyc + lat});
        tick();
        cpu_rd_valid = 1'b0;
    endtask

    task automatic wr_rd(input logic [AW-1:0] a, input logic [7:0] d,
                         input logic [7:0] exp, input int lat);
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = a;
        cpu_wr_data  = d;
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = a;
        chk("both_ready", {30'd0, cpu_wr_ready, cpu_rd_ready}, 32'd3);
        if (cpu_wr_ready && cpu_rd_ready) begin
            wq.push_back('{a, d, cyc + 1});
            rq.push_back('{exp, cyc + lat});
        end
        tick();
        cpu_wr_valid = 1'b0;
        cpu_rd_valid = 1'b0;
    endtask

    task automatic drain_wait(input string nm, input int budget);
        int n = 0;
        while ((wq.size() != 0 || rq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending_writes=%0d pending_reads=%0d",
                     nm, wq.size(), rq.size());
            wq.delete();
            rq.delete();
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n_wr0;
        int n_ret0;

        vt[0] = '{1'b0, 12'h200, 8'h00, 8'h3C, 3};
        vt[1] = '{1'b1, 12'h300, 8'h77, 8'h77, 4};
        vt[2] = '{1'b1, 12'h0FF, 8'hA5, 8'hA5, 4};
        vt[3] = '{1'b0, 12'hFFF, 8'h00, 8'hC3, 3};
        vt[4] = '{1'b1, 12'h000, 8'h5A, 8'h5A, 4};

        reset_n          = 1'b1;
        cpu_wr_valid     = 1'b0;
        cpu_wr_addr      = '0;
        cpu_wr_data      = '0;
        cpu_rd_valid     = 1'b0;
        cpu_rd_addr      = '0;
        render_rd_enable = 1'b0;
        render_rd_addr   = 12'h555;

        #1 reset_n = 1'b0;
        #2;
        chk("rst_wr_ready", 32'(cpu_wr_ready), 32'd1);
        chk("rst_rd_ready", 32'(cpu_rd_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
        chk("rst_rd_valid", 32'(cpu_rd_data_valid), 32'd0);
        chk("rst_rd_data", 32'(cpu_rd_data), 32'd0);
        chk("rst_stall", 32'(render_stall), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            stall_n = 0;
            if (vt[i].wr) begin
                wr_rd(vt[i].a, vt[i].d, vt[i].exp, vt[i].lat);
            end else begin
                read(vt[i].a, vt[i].exp, vt[i].lat, k);
            end
            drain_wait("vec", 50);
            chk("vec_stall", stall_n, 0);
        end

        push(12'h100, 8'hAA, 1);
        push(12'h101, 8'h55, 1);
        drain_wait("seq_order", 20);

        render_rd_enable = 1'b1;
        stall_n = 0;
        push(12'h400, 8'h01, LIMIT + 1);
        push(12'h401, 8'h02, 2 * LIMIT + 1);
        push(12'h402, 8'h03, -1);
        push(12'h403, 8'h04, -1);
        chk("wr_ready_full", 32'(cpu_wr_ready), 32'd0);
        push(12'h404, 8'h05, -1);
        drain_wait("seq_starve_wr", 120);
        chk("starve_wr_stall", stall_n, 0);
        render_rd_enable = 1'b0;
        tick();

        render_rd_enable = 1'b1;
        stall_n = 0;
        read(12'h010, 8'h2C, LIMIT + 3, k);
        drain_wait("seq_starve_rd", 40);
        chk("stall_count", stall_n, 1);
        chk("stall_cycle", stall_cyc, k + LIMIT + 2);
        chk("stall_addr", 32'(stall_addr), 32'h010);
        render_rd_enable = 1'b0;
        tick();

        render_rd_enable = 1'b1;
        push(12'h500, 8'h11, -1);
        push(12'h501, 8'h22, -1);
        push(12'h502, 8'h33, -1);
        read(12'h100, 8'hAA, -1, k);
        tick();
        tick();
        chk("pend_rd_ready", 32'(cpu_rd_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_ready", 32'(cpu_wr_ready), 32'd1);
        chk("mid_rst_rd_ready", 32'(cpu_rd_ready), 32'd1);
        chk("mid_rst_mem_we", 32'(mem_write_enable), 32'd0);
        chk("mid_rst_rd_valid", 32'(cpu_rd_data_valid), 32'd0);
        wq.delete();
        rq.delete();
        render_rd_enable = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        n_wr0  = n_wr;
        n_ret0 = n_ret;
        repeat (20) tick();
        chk("post_rst_writes", n_wr - n_wr0, 0);
        chk("post_rst_returns", n_ret - n_ret0, 0);
        chk("post_rst_wr_ready", 32'(cpu_wr_ready), 32'd1);
        chk("post_rst_rd_ready", 32'(cpu_rd_ready), 32'd1);

        read(12'h500, 8'h3C, 3, k);
        drain_wait("discarded", 20);
        read(12'h100, 8'hAA, 3, k);
        drain_wait("resume", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
